lf_prefix_sum_pipe: RTL and testbench
=====================================

# lf_prefix_sum_pipe

Pipelined, parametrised Ladner-Fischer prefix popcount over a W-bit mask, streaming one mask beat per cycle under valid/ready. A running base is carried across the beats of a frame, so lane counts stay continuous over masks wider than W. It sits between the redundancy-mask generator and the compaction/gather unit, where it supplies per-lane write indices.

## Interface
- `W`, default 128: mask width. Must be a power of 2 and at least 2. L = log2(W) levels.
- `CNT_WIDTH`, default 16: lane count width. Must be at least log2(W)+1. Counts wrap modulo 2^CNT_WIDTH.
- `clk`  in  1  clock. All state is updated on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous. Drops all in-flight beats and zeroes the base.
- `in_valid`  in  1  an input beat is present.
- `in_ready`  out  1  the block accepts the beat.
- `in_mask`  in  W  mask bits. Bit i is lane i.
- `in_last`  in  1  this beat ends the frame.
- `out_valid`  out  1  an output beat is present.
- `out_ready`  in  1  the consumer accepts the beat.
- `out_psum`  out  W*CNT_WIDTH  lane i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
- `out_total`  out  CNT_WIDTH  base + popcount(mask), modulo 2^CNT_WIDTH.
- `out_last`  out  1  in_last of the beat, delayed with it.

## Operation
- Datapath:
  - L Ladner-Fischer levels. Level k (1..L) adds the last lane of the preceding 2^(k-1) block into every lane of each odd 2^(k-1) block.
  - Internal lane width is k+1 bits after level k.
- Registers: one after each of levels 1..L-1. The level-L result plus base goes straight into the output register.
- Inclusive lane i = base + popcount(mask[i:0]), truncated to CNT_WIDTH.
- Base register:
  - Updated only on an output handshake (out_valid && out_ready).
  - Next value: 0 if out_last, otherwise the out_total of that beat.
  - The base is applied at the output stage, so it always reflects all previously accepted beats in order.
- Stall rule:
  - Global enable en = !out_valid || out_ready. Every stage advances only when en is high.
  - in_ready = en && !flush.
  - Bubbles propagate as per-stage valid bits.
- Flush:
  - Clears all stage valid bits, out_valid and the base at the next edge.
  - Flush wins over a simultaneous input beat (the beat is not accepted) and over a simultaneous output handshake (the base still goes to 0).
- Reset values: out_valid=0, out_psum=0, out_total=0, out_last=0, base=0, all stage valids=0. in_ready is 1 on the first cycle after reset release.
- Reset asserted mid-frame discards every beat in flight. No partial output is produced.

## Timing
- A beat accepted at edge E0 is on out_* from edge E0+L-1. For W=128 that is 6 edges later (7 register stages including the output).
- Throughput is one beat per cycle while out_ready=1.
- out_* holds stable while out_valid && !out_ready.
- in_ready is combinational from out_valid, out_ready and flush. It has no dependency on in_valid.
- A frame is one or more beats. A single beat with in_last=1 is a complete frame.

## Configuration
- `PREFIX_SUM_EXCLUSIVE_EN`:
  - Defined: exclusive scan. Lane i = base + popcount(mask[i-1:0]), and lane 0 = base. Implemented by shifting the level-L result one lane up at the output stage.
  - Undefined: inclusive scan as above.
  - out_total is identical in both modes.

## Structure
- Package `prefix_sum_pkg` holds:
  - `lf_levels(W)` constant function.
  - `lane_width(k)` = k+1.
  - Parameter legality checks.
- Sub-module `lf_prefix_level`:
  - Combinational, parametrised by W and level index k.
  - Input lanes are k bits wide; output lanes are k+1 bits wide.
  - Instantiated L times. Pipeline registers live in the top module.

## Test plan
- Single beat, in_mask all ones, in_last=1 → lane i = i+1, out_total=128, out_last=1, out_valid 6 edges after acceptance.
- Frame of two beats: mask 0x...000F with last=0, then all ones with last=1 → beat 2 lane i = 5+i, out_total=132. The next frame's all-ones beat gives lane 0 = 1.
- Stream 20 random beats while out_ready toggles (low for 5 cycles mid-stream) → outputs match the reference model in order with no drop or duplicate. in_ready=0 whenever out_valid && !out_ready.
- flush asserted with 3 beats in flight mid-frame, together with in_valid=1 → in_ready=0, no out_valid from the dropped beats. The next beat with mask=1 gives lane 0 = 1 (base 0).
- CNT_WIDTH=8, three all-ones beats with last=0 → beat 3 lane 0 = (256+1) mod 256 = 1, out_total = 384 mod 256 = 128.
- With `PREFIX_SUM_EXCLUSIVE_EN` defined, single beat mask=0x1, last=1 → lane 0 = 0, lanes 1..127 = 1, out_total=1. reset_n pulsed mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/prefix_sum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prefix_sum_pkg
// Description : Shared helpers for the Ladner-Fischer prefix popcount pipeline
//               (level count, lane widths, flat-bus offsets, legality check).
// Revision    : 1.0 - initial release
// ============================================================================
package prefix_sum_pkg;

    function automatic int lf_levels(input int w);
        return $clog2(w);
    endfunction

    function automatic int lane_width(input int k);
        return k + 1;
    endfunction

    // Bit offset of the level-k result inside the flat bus holding levels 1..L.
    function automatic int seg_off(input int w, input int k);
        return w * (((k * (k + 1)) / 2) - 1);
    endfunction

    function automatic bit params_ok(input int w, input int cnt_width);
        return (w >= 2) && ((w & (w - 1)) == 0) && (cnt_width >= $clog2(w) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lf_prefix_level.sv
`default_nettype none
// ============================================================================
// Module      : lf_prefix_level
// Description : One combinational Ladner-Fischer level: every lane of an odd
//               2^(K-1) block gains the last lane of the block before it.
// Revision    : 1.0 - initial release
// ============================================================================
module lf_prefix_level
    import prefix_sum_pkg::*;
#(
    parameter int W = 128,
    parameter int K = 1
) (
    input  logic [W*K-1:0]             i_lanes,
    output logic [W*lane_width(K)-1:0] o_lanes
);

    localparam int BLK = 1 << (K - 1);
    localparam int OW  = lane_width(K);

    for (genvar i = 0; i < W; i++) begin : g_lane
        localparam int J = i / BLK;
        if ((J % 2) == 1) begin : g_add
            assign o_lanes[i*OW +: OW] = {1'b0, i_lanes[i*K +: K]}
                                       + {1'b0, i_lanes[(J*BLK-1)*K +: K]};
        end else begin : g_pass
            assign o_lanes[i*OW +: OW] = {1'b0, i_lanes[i*K +: K]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/lf_prefix_sum_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lf_prefix_sum_pipe
// Description : Pipelined Ladner-Fischer prefix popcount with a running frame
//               base. Define PREFIX_SUM_EXCLUSIVE_EN for an exclusive scan.
// Revision    : 1.0 - initial release
// ============================================================================
module lf_prefix_sum_pipe
    import prefix_sum_pkg::*;
#(
    parameter int W         = 128,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_mask,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W*CNT_WIDTH-1:0] out_psum,
    output logic [CNT_WIDTH-1:0]   out_total,
    output logic                   out_last
);

    localparam int L      = lf_levels(W);
    localparam int LW     = lane_width(L);
    localparam int BUS_W  = seg_off(W, L + 1);
    localparam int PIPE_W = (L > 1) ? seg_off(W, L) : 1;

    if (!params_ok(W, CNT_WIDTH)) begin : g_bad_param
        $error("lf_prefix_sum_pipe: W must be a power of 2 >= 2 and CNT_WIDTH >= log2(W)+1");
    end

    logic                   w_en;
    logic [BUS_W-1:0]       w_lvl;
    logic [PIPE_W-1:0]      r_pipe;
    logic [L-1:0]           r_vld;
    logic [L-1:0]           r_lst;
    logic [CNT_WIDTH-1:0]   r_base;
    logic [CNT_WIDTH-1:0]   w_base_nxt;
    logic [W*LW-1:0]        w_fin;
    logic [W*CNT_WIDTH-1:0] w_psum_nxt;
    logic [CNT_WIDTH-1:0]   w_total_nxt;
    logic [W*CNT_WIDTH-1:0] r_psum;
    logic [CNT_WIDTH-1:0]   r_total;

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en && !flush;

    // Level k output sits at seg_off(W,k); levels 1..L-1 share the register layout.
    for (genvar k = 1; k <= L; k++) begin : g_lvl
        logic [W*k-1:0] w_in;
        if (k == 1) begin : g_first
            assign w_in = in_mask;
        end else begin : g_mid
            assign w_in = r_pipe[seg_off(W, k-1) +: W*k];
        end
        lf_prefix_level #(
            .W (W),
            .K (k)
        ) u_level (
            .i_lanes (w_in),
            .o_lanes (w_lvl[seg_off(W, k) +: W*lane_width(k)])
        );
    end

    if (L > 1) begin : g_pipe
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_pipe <= '0;
            end else if (w_en) begin
                r_pipe <= w_lvl[PIPE_W-1:0];
            end
        end
    end else begin : g_no_pipe
        assign r_pipe = '0;
    end

    // The beat entering the output register must see the base as updated by
    // the handshake happening on the same edge.
    assign w_base_nxt = (out_valid && out_ready) ? (out_last ? '0 : out_total) : r_base;
    assign w_fin      = w_lvl[seg_off(W, L) +: W*LW];

    for (genvar i = 0; i < W; i++) begin : g_out
`ifdef PREFIX_SUM_EXCLUSIVE_EN
        if (i == 0) begin : g_lane0
            assign w_psum_nxt[0 +: CNT_WIDTH] = w_base_nxt;
        end else begin : g_lanen
            assign w_psum_nxt[i*CNT_WIDTH +: CNT_WIDTH] =
                w_base_nxt + CNT_WIDTH'(w_fin[(i-1)*LW +: LW]);
        end
`else
        assign w_psum_nxt[i*CNT_WIDTH +: CNT_WIDTH] =
            w_base_nxt + CNT_WIDTH'(w_fin[i*LW +: LW]);
`endif
    end

    assign w_total_nxt = w_base_nxt + CNT_WIDTH'(w_fin[(W-1)*LW +: LW]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld  <= '0;
            r_lst  <= '0;
            r_base <= '0;
        end else if (flush) begin
            r_vld  <= '0;
            r_base <= '0;
        end else if (w_en) begin
            r_vld[0] <= in_valid;
            r_lst[0] <= in_last;
            for (int k = 1; k < L; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_lst[k] <= r_lst[k-1];
            end
            r_base <= w_base_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_psum  <= '0;
            r_total <= '0;
        end else if (w_en) begin
            r_psum  <= w_psum_nxt;
            r_total <= w_total_nxt;
        end
    end

    assign out_valid = r_vld[L-1];
    assign out_last  = r_lst[L-1];
    assign out_psum  = r_psum;
    assign out_total = r_total;

endmodule
`default_nettype wire

// File: tb/tb_lf_prefix_sum_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_lf_prefix_sum_pipe
// Description : Self-checking bench for lf_prefix_sum_pipe (W=128, CNT_WIDTH
//               16 and 8) against a running-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lf_prefix_sum_pipe;

    localparam int W = 128;
    localparam int C = 16;
    localparam int L = 7;
`ifdef PREFIX_SUM_EXCLUSIVE_EN
    localparam int EXC = 1;
`else
    localparam int EXC = 0;
`endif

    typedef struct packed {
        logic [W*C-1:0] psum;
        logic [C-1:0]   total;
        logic           last;
    } beat_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           flush;
    logic           in_valid;
    logic [W-1:0]   in_mask;
    logic           in_last;
    logic           out_ready;
    logic           in_ready,  in_ready8;
    logic           out_valid, out_valid8;
    logic           out_last,  out_last8;
    logic [W*C-1:0] out_psum;
    logic [W*8-1:0] out_psum8;
    logic [C-1:0]   out_total;
    logic [7:0]     out_total8;

    beat_t          q[$];
    beat_t          log_q[$];
    logic [W*8-1:0] log8_psum[$];
    logic [7:0]     log8_total[$];
    logic [C-1:0]   m_base;
    bit             last_acc;
    int             n_assert = 0;
    int             n_fail   = 0;

    lf_prefix_sum_pipe #(.W(W), .CNT_WIDTH(C)) u_dut (
        .clk (clk), .reset_n (reset_n), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready), .in_mask (in_mask), .in_last (in_last),
        .out_valid (out_valid), .out_ready (out_ready), .out_psum (out_psum),
        .out_total (out_total), .out_last (out_last)
    );

    lf_prefix_sum_pipe #(.W(W), .CNT_WIDTH(8)) u_dut8 (
        .clk (clk), .reset_n (reset_n), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready8), .in_mask (in_mask), .in_last (in_last),
        .out_valid (out_valid8), .out_ready (out_ready), .out_psum (out_psum8),
        .out_total (out_total8), .out_last (out_last8)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Lane i counts set mask bits up to lane i (or below it, exclusive scan).
    function automatic beat_t ref_beat(input logic [W-1:0] m, input logic [C-1:0] base,
                                       input logic l);
        beat_t b;
        int    run;
        run = 0;
        for (int i = 0; i < W; i++) begin
            if (EXC == 1) begin
                b.psum[i*C +: C] = base + C'(run);
                run += m[i] ? 1 : 0;
            end else begin
                run += m[i] ? 1 : 0;
                b.psum[i*C +: C] = base + C'(run);
            end
        end
        b.total = base + C'(run);
        b.last  = l;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_psum(input string tag, input logic [W*C-1:0] got, input logic [W*C-1:0] exp);
        int bad;
        bad = 0;
        n_assert++;
        assert (got === exp) else begin
            for (int i = W-1; i >= 0; i--) if (got[i*C +: C] !== exp[i*C +: C]) bad = i;
            n_fail++;
            $error("FAIL %s lane %0d: observed %0h expected %0h", tag, bad,
                   got[bad*C +: C], exp[bad*C +: C]);
        end
    endtask

    task automatic chk_psum8(input string tag, input logic [W*8-1:0] got, input logic [W*8-1:0] exp);
        int bad;
        bad = 0;
        n_assert++;
        assert (got === exp) else begin
            for (int i = W-1; i >= 0; i--) if (got[i*8 +: 8] !== exp[i*8 +: 8]) bad = i;
            n_fail++;
            $error("FAIL %s lane %0d: observed %0h expected %0h", tag, bad,
                   got[bad*8 +: 8], exp[bad*8 +: 8]);
        end
    endtask

    // One clock: drive at the falling edge, check just after, update the model.
    task automatic cyc(input bit v, input logic [W-1:0] m, input bit l, input bit ordy, input bit fl);
        bit             exp_rdy;
        beat_t          e;
        beat_t          obs;
        logic [W*8-1:0] e8;
        @(negedge clk);
        in_valid  = v;
        in_mask   = m;
        in_last   = l;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = (!out_valid || ordy) && !fl;
        chk("in_ready", in_ready, exp_rdy);
        chk("in_ready8", in_ready8, exp_rdy);
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                chk_psum("out_psum", out_psum, e.psum);
                chk("out_total", out_total, e.total);
                chk("out_last", out_last, e.last);
                for (int i = 0; i < W; i++) e8[i*8 +: 8] = e.psum[i*C +: 8];
                chk("out_valid8", out_valid8, 1'b1);
                chk_psum8("out_psum8", out_psum8, e8);
                chk("out_total8", out_total8, e.total[7:0]);
                obs.psum  = out_psum;
                obs.total = out_total;
                obs.last  = out_last;
                log_q.push_back(obs);
                log8_psum.push_back(out_psum8);
                log8_total.push_back(out_total8);
            end
        end
        last_acc = v && exp_rdy;
        if (fl) begin
            q.delete();
            m_base = '0;
        end else if (last_acc) begin
            e = ref_beat(m, m_base, l);
            q.push_back(e);
            m_base = l ? '0 : e.total;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() > 0 && n < budget) begin
            cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        chk("drain_pending_beats", q.size(), 0);
    endtask

    initial begin
        beat_t b;
        int    n0;
        int    acc_n;
        int    k;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        m_base    = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_total", out_total, 0);
        chk("reset_out_last", out_last, 1'b0);
        chk_psum("reset_out_psum", out_psum, '0);
        chk("reset_in_ready", in_ready, 1'b1);

        // Single all-ones beat: latency and lane values.
        n0 = log_q.size();
        cyc(1'b1, '1, 1'b1, 1'b1, 1'b0);
        for (int j = 1; j <= L; j++) begin
            cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
            chk("latency_out_valid", out_valid, (j == L));
        end
        b = log_q[n0];
        chk("t1_lane0", b.psum[0 +: C], 1 - EXC);
        chk("t1_lane127", b.psum[127*C +: C], 128 - EXC);
        chk("t1_total", b.total, 128);
        chk("t1_last", b.last, 1'b1);

        // Two-beat frame, then a fresh frame.
        n0 = log_q.size();
        cyc(1'b1, 128'hF, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, '1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, '1, 1'b1, 1'b1, 1'b0);
        drain(40);
        chk("t2_count", log_q.size() - n0, 3);
        b = log_q[n0+1];
        chk("t2_b2_lane0", b.psum[0 +: C], 5 - EXC);
        chk("t2_b2_lane127", b.psum[127*C +: C], 132 - EXC);
        chk("t2_b2_total", b.total, 132);
        b = log_q[n0+2];
        chk("t2_b3_lane0", b.psum[0 +: C], 1 - EXC);

        // Random stream with a 5-cycle consumer stall.
        acc_n = 0;
        k = 0;
        while (acc_n < 20 && k < 200) begin
            cyc($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 4) == 0, !(k >= 6 && k < 11), 1'b0);
            if (last_acc) acc_n++;
            k++;
        end
        chk("t3_accepted", acc_n, 20);
        drain(60);

        // Flush with beats in flight mid-frame.
        cyc(1'b1, 128'hFF, 1'b0, 1'b1, 1'b0);
        drain(40);
        for (int j = 0; j < 3; j++)
            cyc(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, '1, 1'b0, 1'b1, 1'b1);
        chk("flush_in_ready", in_ready, 1'b0);
        for (int j = 0; j < 10; j++) begin
            cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
            chk("flush_no_out_valid", out_valid, 1'b0);
        end
        n0 = log_q.size();
        cyc(1'b1, 128'h1, 1'b1, 1'b1, 1'b0);
        drain(40);
        b = log_q[n0];
        chk("t4_lane0", b.psum[0 +: C], 1 - EXC);
        chk("t4_total", b.total, 1);

        // Count wrap on the 8-bit instance.
        n0 = log_q.size();
        for (int j = 0; j < 3; j++) cyc(1'b1, '1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, '0, 1'b1, 1'b1, 1'b0);
        drain(40);
        chk("t5_cnt8_lane0", log8_psum[n0+2][7:0], 1 - EXC);
        chk("t5_cnt8_total", log8_total[n0+2], 128);
        chk("t5_cnt16_lane0", log_q[n0+2].psum[0 +: C], 257 - EXC);
        chk("t5_cnt16_total", log_q[n0+2].total, 384);

        // Single beat with only lane 0 set.
        n0 = log_q.size();
        cyc(1'b1, 128'h1, 1'b1, 1'b1, 1'b0);
        drain(40);
        b = log_q[n0];
        chk("t6_lane0", b.psum[0 +: C], 1 - EXC);
        chk("t6_lane1", b.psum[1*C +: C], 1);
        chk("t6_lane127", b.psum[127*C +: C], 1);
        chk("t6_total", b.total, 1);

        // Asynchronous reset with a stalled, valid output.
        for (int j = 0; j < 3; j++)
            cyc(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 10; j++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_out_valid", out_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_out_valid", out_valid, 1'b0);
        chk("async_reset_out_total", out_total, 0);
        chk_psum("async_reset_out_psum", out_psum, '0);
        q.delete();
        m_base = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n0 = log_q.size();
        cyc(1'b1, '1, 1'b1, 1'b1, 1'b0);
        drain(40);
        b = log_q[n0];
        chk("t7_lane0", b.psum[0 +: C], 1 - EXC);
        chk("t7_total", b.total, 128);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
